// File: rtl/seq_mux_scanner.sv
// seq_mux_scanner: registered CH-to-1 channel mux with fixed/scan/sweep control FSM
module seq_mux_scanner #(
  parameter int CH = 8,
  parameter int W = 4,
  parameter int DWELL = 4,
  localparam int SELW = $clog2(CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH*W-1:0]   in_data,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [SELW-1:0]   sel_in,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  output logic              out_valid,
  output logic              sweep_done
);
  localparam int DCW = DWELL > 1 ? $clog2(DWELL) : 1;
  typedef enum logic [2:0] {IDLE, FIXED, SCAN, SWEEP, DONE} state_t;
  state_t state, state_n, want;
  logic [SELW-1:0] ch_ptr, ch_ptr_n, cur, out_ch_n;
  logic [DCW-1:0] dwell_cnt, dwell_n;
  logic [W-1:0] out_data_n;
  logic out_valid_n, sweep_done_n, cur_ok, last_dwell, last_ch, change;
  always_comb begin
    want = mode == 2'b01 ? SCAN : mode == 2'b10 ? SWEEP : FIXED;
    cur = state == FIXED ? sel_in : ch_ptr;
    cur_ok = {1'b0, cur} < (SELW+1)'(CH);
    last_dwell = dwell_cnt == DCW'(DWELL - 1);
    last_ch = ch_ptr == SELW'(CH - 1);
    // DONE counts as "still in SWEEP mode" so it only leaves on a real mode change
    change = state == DONE ? want != SWEEP : want != state;
    state_n = state;
    ch_ptr_n = ch_ptr;
    dwell_n = dwell_cnt;
    out_data_n = out_data;
    out_ch_n = out_ch;
    out_valid_n = 1'b0;
    sweep_done_n = 1'b0;
    if (!en) begin
      state_n = IDLE;
    end else if (change) begin
      state_n = want;
      ch_ptr_n = '0;
      dwell_n = '0;
    end else if (state != DONE) begin
      out_data_n = cur_ok ? in_data[cur*W +: W] : '0;
      out_ch_n = cur;
      out_valid_n = cur_ok;
      if (state != FIXED) begin
        dwell_n = last_dwell ? '0 : dwell_cnt + DCW'(1);
        ch_ptr_n = !last_dwell ? ch_ptr : last_ch ? '0 : ch_ptr + SELW'(1);
        if (state == SWEEP && last_dwell && last_ch) begin
          state_n = DONE;
          sweep_done_n = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch_ptr <= '0;
      dwell_cnt <= '0;
      out_data <= '0;
      out_ch <= '0;
      out_valid <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state <= state_n;
      ch_ptr <= ch_ptr_n;
      dwell_cnt <= dwell_n;
      out_data <= out_data_n;
      out_ch <= out_ch_n;
      out_valid <= out_valid_n;
      sweep_done <= sweep_done_n;
    end
  end
endmodule

// File: tb/tb_seq_mux_scanner.sv
// tb_seq_mux_scanner: vector table, scan/sweep sequences and randomized run against a step-count model
module tb_seq_mux_scanner;
  localparam int CH = 8, W = 4, DWELL = 2, SELW = 3;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [SELW-1:0] sel_in = '0;
  logic [CH*W-1:0] in_data;
  logic [W-1:0] out_data;
  logic [SELW-1:0] out_ch;
  logic out_valid, sweep_done;
  logic [W-1:0] chans [CH];
  int pass_cnt = 0, total = 0;
  typedef struct {
    logic rst, en;
    logic [1:0] mode;
    logic [SELW-1:0] sel;
    logic [W-1:0] d;
    logic [SELW-1:0] c;
    logic v, s;
  } vec_t;
  vec_t tv[$];
  bit m_act, m_fin;
  int m_run, k, eff, c;
  logic [W-1:0] e_d;
  logic [SELW-1:0] e_c;
  logic e_v, e_s;

  seq_mux_scanner #(.CH(CH), .W(W), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .en(en), .mode(mode), .sel_in(sel_in),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  task automatic pack();
    for (int i = 0; i < CH; i++) in_data[i*W +: W] = chans[i];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, e, input logic [1:0] m, input logic [SELW-1:0] s,
                     input logic [W-1:0] d, input logic [SELW-1:0] ch, input logic v, sd);
    vec_t x;
    x.rst = r; x.en = e; x.mode = m; x.sel = s; x.d = d; x.c = ch; x.v = v; x.s = sd;
    tv.push_back(x);
  endtask

  task automatic check(input string name, input logic [W-1:0] d, input logic [SELW-1:0] ch,
                       input logic v, s);
    total++;
    if ({out_data, out_ch, out_valid, sweep_done} === {d, ch, v, s}) pass_cnt++;
    else $display("FAIL %s @%0t: got data=%0d ch=%0d valid=%0b done=%0b, want data=%0d ch=%0d valid=%0b done=%0b",
                  name, $time, out_data, out_ch, out_valid, sweep_done, d, ch, v, s);
  endtask

  initial begin
    for (int i = 0; i < CH; i++) chans[i] = W'(i + 1);
    pack();
    rst = 1; en = 0;
    tick(); check("reset0", 0, 0, 0, 0);
    tick(); check("reset1", 0, 0, 0, 0);
    rst = 0;
    for (int i = 0; i < 10; i++) begin tick(); check("idle", 0, 0, 0, 0); end

    add(0, 1, 0, 5, 0, 0, 0, 0);
    add(0, 1, 0, 5, 6, 5, 1, 0);
    add(0, 1, 0, 2, 3, 2, 1, 0);
    add(0, 1, 1, 2, 3, 2, 0, 0);
    add(0, 1, 1, 2, 1, 0, 1, 0);
    add(0, 1, 1, 2, 1, 0, 1, 0);
    add(0, 1, 1, 2, 2, 1, 1, 0);
    add(0, 1, 0, 7, 2, 1, 0, 0);
    add(0, 1, 0, 7, 8, 7, 1, 0);
    add(0, 0, 0, 7, 8, 7, 0, 0);
    add(0, 0, 0, 7, 8, 7, 0, 0);
    add(0, 1, 3, 3, 8, 7, 0, 0);
    add(0, 1, 3, 3, 4, 3, 1, 0);
    add(0, 1, 3, 6, 7, 6, 1, 0);
    add(1, 1, 3, 6, 0, 0, 0, 0);
    foreach (tv[i]) begin
      rst = tv[i].rst; en = tv[i].en; mode = tv[i].mode; sel_in = tv[i].sel;
      tick();
      check($sformatf("vec%0d", i), tv[i].d, tv[i].c, tv[i].v, tv[i].s);
    end

    rst = 0; en = 1; mode = 2'b01;
    tick(); check("scan_start", 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick(); check("scan", W'((i/2)%8 + 1), SELW'((i/2)%8), 1, 0);
    end
    en = 0;
    tick(); check("scan_en_low", 2, 1, 0, 0);

    en = 1; mode = 2'b10;
    tick(); check("sweep_start", 2, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      tick(); check("sweep", W'(i/2 + 1), SELW'(i/2), 1, i == 15);
    end
    for (int i = 0; i < 3; i++) begin tick(); check("sweep_done_hold", 8, 7, 0, 0); end
    en = 0;
    tick(); check("sweep_en_low", 8, 7, 0, 0);
    en = 1;
    tick(); check("sweep_restart_start", 8, 7, 0, 0);
    for (int i = 0; i < 9; i++) begin
      tick(); check("sweep_restart", W'(i/2 + 1), SELW'(i/2), 1, 0);
    end
    rst = 1;
    tick(); check("sweep_rst", 0, 0, 0, 0);
    rst = 0; en = 0;
    for (int i = 0; i < 4; i++) begin tick(); check("no_done_after_rst", 0, 0, 0, 0); end

    rst = 1;
    m_act = 0; m_fin = 0; m_run = 0; k = 0;
    e_d = 0; e_c = 0; e_v = 0; e_s = 0;
    tick(); check("rand_reset", 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom % 250) == 0;
      en = ($urandom % 25) != 0;
      if (($urandom % 30) == 0) mode = 2'($urandom);
      sel_in = SELW'($urandom);
      for (int i = 0; i < CH; i++) chans[i] = W'($urandom);
      pack();
      eff = mode == 2'b01 ? 1 : mode == 2'b10 ? 2 : 0;
      if (rst) begin
        m_act = 0; e_d = 0; e_c = 0; e_v = 0; e_s = 0;
      end else if (!en) begin
        m_act = 0; e_v = 0; e_s = 0;
      end else if (!m_act || eff != m_run) begin
        m_act = 1; m_run = eff; k = 0; m_fin = 0; e_v = 0; e_s = 0;
      end else if (m_fin) begin
        e_v = 0; e_s = 0;
      end else begin
        c = m_run == 0 ? int'(sel_in) : (k / DWELL) % CH;
        e_d = chans[c]; e_c = SELW'(c); e_v = 1; e_s = 0;
        k++;
        if (m_run == 2 && k == CH*DWELL) begin m_fin = 1; e_s = 1; end
      end
      tick();
      check("rand", e_d, e_c, e_v, e_s);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
